// File: rtl/i2c_bit_timer.sv
// i2c_bit_timer: programmable down-counting tick timer for I2C bit timing.
// A start loads the period from ticks. Each enabled cycle (stop low) counts
// down by one. At terminal count the timer emits a one-cycle out pulse and
// reloads from ticks. Stop freezes the count so a bit period can be stretched.
module i2c_bit_timer #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic [SIZE-1:0] ticks,
  output logic            out
);

  // Reload threshold: a count of 1 (or 0 after reset / a zero load) ends the period.
  localparam logic [SIZE-1:0] CNT_ONE = {{(SIZE-1){1'b0}}, 1'b1};

  logic [SIZE-1:0] cnt_r;
  logic            out_r;
  logic [SIZE-1:0] cnt_nxt_s;
  logic            out_nxt_s;
  logic            term_s;

  // Terminal count: at 1 or 0 the next enabled edge reloads, so the count never underflows.
  always_comb begin
    term_s = 1'b0;
    if (cnt_r <= CNT_ONE) begin
      term_s = 1'b1;
    end else begin
      term_s = 1'b0;
    end
  end

  // Next-state selection: start beats stop, stop beats counting.
  always_comb begin
    cnt_nxt_s = cnt_r;
    out_nxt_s = 1'b0;
    if (start) begin
      cnt_nxt_s = ticks;
      out_nxt_s = 1'b0;
    end else if (stop) begin
      cnt_nxt_s = cnt_r;
      out_nxt_s = 1'b0;
    end else if (term_s) begin
      cnt_nxt_s = ticks;
      out_nxt_s = 1'b1;
    end else begin
      cnt_nxt_s = cnt_r - CNT_ONE;
      out_nxt_s = 1'b0;
    end
  end

  // Counter and pulse registers; reset clears both asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {SIZE{1'b0}};
      out_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      out_r <= out_nxt_s;
    end
  end

  assign out = out_r;

endmodule

// File: tb/tb_i2c_bit_timer.sv
// Self-checking bench for i2c_bit_timer: a vector table for short behaviours
// plus hand-written long sequences, all compared through a scoreboard queue.
module tb_i2c_bit_timer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] ticks;
  logic       out;

  int tests;
  int fails;

  typedef struct {
    bit       r;
    bit       s;
    bit       p;
    bit [7:0] t;
    bit       e;
  } vec_t;

  typedef struct {
    bit    e;
    string tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  i2c_bit_timer #(.SIZE(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .stop (stop),
    .ticks(ticks),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it with out.
  task automatic check_out();
    exp_t x;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty: no expectation queued");
    end else begin
      x = sb.pop_front();
      tests++;
      if (out !== x.e) begin
        fails++;
        $display("FAIL %s: out=%0b expected %0b", x.tag, out, x.e);
      end
    end
  endtask

  // Drive one cycle of inputs, queue the expected out, sample after the edge.
  task automatic drive(input bit r, input bit s, input bit p,
                       input bit [7:0] t, input bit e, input string tag);
    exp_t x;
    @(negedge clk);
    rst   = r;
    start = s;
    stop  = p;
    ticks = t;
    x.e   = e;
    x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    ticks = 8'd0;

    // ---- vector table: {rst, start, stop, ticks, expected out} ----
    // reset with start and stop high
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'd3, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'd3, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'd3, 1'b0});
    // released, held: no pulse while stop high
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'd3, 1'b0});
    // first enabled edge after reset: cnt=0 pulses and reloads 3
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd3, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd3, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd3, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd3, 1'b1});
    // start and stop together load 2; ticks change to 5 does not alter it
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'd2, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd5, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd5, 1'b1});
    // cnt=5 in progress; ticks=1 only matters at the next reload
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd1, 1'b1});
    // hold with ticks=1: no pulse, then pulse resumes
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'd1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'd1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd1, 1'b1});
    // ticks=0 pulses every enabled edge
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 1'b1});
    // start held high keeps reloading with out low
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'd0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'd4, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'd4, 1'b0});
    // period of 4 after the final load
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd4, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd4, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd4, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd4, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd4, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].t, vecs[i].e, $sformatf("vec%0d", i));
    end

    // ---- basic count and auto-reload with ticks=0xAA ----
    drive(1'b1, 1'b0, 1'b0, 8'hAA, 1'b0, "basic_rst");
    drive(1'b0, 1'b1, 1'b0, 8'hAA, 1'b0, "basic_start");
    drive(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, "basic_stop");
    for (int i = 1; i <= 170; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'hAA, (i == 170), $sformatf("basic_edge%0d", i));
    end
    for (int i = 1; i <= 170; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'hAA, (i == 170), $sformatf("reload_edge%0d", i));
    end

    // ---- two periods each stretched by a 4-cycle hold at 85 remaining ----
    for (int p = 0; p < 2; p++) begin
      for (int i = 1; i <= 174; i++) begin
        drive(1'b0, 1'b0, (i > 85 && i <= 89), 8'hAA, (i == 174),
              $sformatf("hold_p%0d_c%0d", p, i));
      end
    end

    // ---- priority and restart with ticks=10 ----
    drive(1'b0, 1'b1, 1'b1, 8'd10, 1'b0, "prio_load");
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'd10, 1'b0, $sformatf("prio_pre%0d", i));
    end
    drive(1'b0, 1'b1, 1'b0, 8'd10, 1'b0, "restart");
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'd10, (i == 10), $sformatf("restart_edge%0d", i));
    end

    // ---- ticks=0xFF: period of 255 ----
    drive(1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, "ff_start");
    for (int i = 1; i <= 510; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'hFF, (i == 255 || i == 510), $sformatf("ff_edge%0d", i));
    end

    // ---- asynchronous reset while out is high ----
    drive(1'b0, 1'b1, 1'b0, 8'd20, 1'b0, "arst_start");
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'd20, (i == 20), $sformatf("arst_edge%0d", i));
    end
    #1;
    rst = 1'b1;
    #1;
    tests++;
    if (out !== 1'b0) begin
      fails++;
      $display("FAIL arst_immediate: out=%0b expected 0", out);
    end
    drive(1'b1, 1'b0, 1'b0, 8'd20, 1'b0, "arst_held");
    drive(1'b0, 1'b0, 1'b0, 8'd20, 1'b1, "arst_first_edge");
    drive(1'b0, 1'b0, 1'b0, 8'd20, 1'b0, "arst_after_pulse");

    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
